i2c_master_controller: RTL and testbench

I2C_MASTER_CONTROLLER -- requirements
Module: i2c_master_controller

---
 rtl/i2c_master_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_master_controller.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_controller.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte written or read, STOP.
// SCL is push-pull and never stretched; SDA is open-drain (pulled low or released).
module i2c_master_controller #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       enable,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);

  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DIV_LAST = CLK_DIV - 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic             rw_q, rw_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rshift_q, rshift_d;
  logic [7:0]       dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             scl_q, scl_d;
  logic             sda_oe_q, sda_oe_d;
  logic [1:0]       sda_sync_q;

  logic             sda_in;
  logic             div_last;
  logic             period_end;
  logic             sample_now;
  logic [7:0]       addr_byte;

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign sda_in   = sda_sync_q[1];
  assign data_out = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_err  = ack_err_q;
  assign scl      = scl_q;

  // Two-flop synchronizer on the external SDA line
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sda_sync_q <= 2'b11;
    end else begin
      sda_sync_q <= {sda_sync_q[0], sda};
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rshift_q  <= '0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rshift_q  <= rshift_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rshift_d   = rshift_q;
    dout_d     = dout_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_err_d  = ack_err_q;
    scl_d      = 1'b1;
    sda_oe_d   = 1'b0;

    div_last   = (div_q == DIV_W'(DIV_LAST));
    period_end = div_last && (qtr_q == 2'd3);
    sample_now = (qtr_q == 2'd2) && (div_q == '0);

    if (state_q == S_IDLE) begin
      if (enable) begin
        rw_d      = rw;
        addr_d    = addr;
        wdata_d   = data_in;
        ack_err_d = 1'b0;
        busy_d    = 1'b1;
        div_d     = '0;
        qtr_d     = '0;
        state_d   = S_START;
      end
    end else begin
      // Quarter timebase: the quarter index wraps 3->0 at each bit-period end
      if (div_last) begin
        div_d = '0;
        qtr_d = qtr_q + 2'd1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end

      case (state_q)
        S_START: begin
          if (period_end) begin
            bit_d   = 3'd7;
            state_d = S_ADDR;
          end
        end
        S_ADDR: begin
          if (period_end) begin
            if (bit_q == 3'd0) state_d = S_ADDR_ACK;
            else               bit_d   = bit_q - 3'd1;
          end
        end
        S_ADDR_ACK: begin
          if (sample_now && sda_in) ack_err_d = 1'b1;
          if (period_end) begin
            bit_d = 3'd7;
            if (ack_err_q)  state_d = S_STOP;
            else if (rw_q) state_d = S_RD_DATA;
            else           state_d = S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (period_end) begin
            if (bit_q == 3'd0) state_d = S_WR_ACK;
            else               bit_d   = bit_q - 3'd1;
          end
        end
        S_WR_ACK: begin
          if (sample_now && sda_in) ack_err_d = 1'b1;
          if (period_end) state_d = S_STOP;
        end
        S_RD_DATA: begin
          if (sample_now) rshift_d = {rshift_q[6:0], sda_in};
          if (period_end) begin
            if (bit_q == 3'd0) begin
              dout_d  = rshift_q;
              state_d = S_RD_ACK;
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (period_end) state_d = S_STOP;
        end
        S_STOP: begin
          if (period_end) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Line levels are derived from the next phase so the registered pins track state_q exactly
    addr_byte = {addr_d, rw_d};
    case (state_d)
      S_START: begin
        scl_d    = (qtr_d != 2'd3);
        sda_oe_d = (qtr_d != 2'd0);
      end
      S_ADDR: begin
        scl_d    = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_oe_d = ~addr_byte[bit_d];
      end
      S_WR_DATA: begin
        scl_d    = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_oe_d = ~wdata_d[bit_d];
      end
      S_ADDR_ACK, S_WR_ACK, S_RD_DATA, S_RD_ACK: begin
        scl_d    = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_oe_d = 1'b0;
      end
      S_STOP: begin
        scl_d    = (qtr_d != 2'd0);
        sda_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd1);
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Scoreboard bench for i2c_master_controller with a bus-level responder at 7'b0101010.
module tb_i2c_master_controller;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned PERIOD     = 4 * CLK_DIV;
  localparam logic [6:0]  SLAVE_ADDR = 7'b0101010;
  localparam logic [7:0]  SLAVE_DATA = 8'b01101011;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic [7:0]  dout;
    logic        aerr;
    int unsigned start;
    int unsigned lat;
  } exp_t;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
  } frame_t;

  logic       clk     = 1'b0;
  logic       RST     = 1'b1;
  logic       enable  = 1'b0;
  logic       rw      = 1'b0;
  logic [6:0] addr    = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       scl;
  wire        sda;
  logic       slv_oe  = 1'b0;

  assign sda = slv_oe ? 1'b0 : 1'bz;
  pullup pu_sda (sda);

  int          checks     = 0;
  int          failures   = 0;
  int unsigned cyc        = 0;
  logic [7:0]  model_dout = 8'h00;
  logic        resp_abort = 1'b0;
  exp_t        exp_q[$];
  frame_t      frame_q[$];

  i2c_master_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .RST     (RST),
    .enable  (enable),
    .rw      (rw),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .scl     (scl),
    .sda     (sda)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Bus responder: decodes START/STOP, records every bit seen on a SCL rise, ACKs its address
  logic        prev_scl = 1'b1, prev_sda = 1'b1, cur_scl, cur_sda;
  logic        in_frame = 1'b0, matched = 1'b0, rd = 1'b0;
  int          rise_cnt = 0;
  logic [31:0] fbits    = '0;
  logic [7:0]  sdat;

  initial begin : responder
    frame_t fr;
    sdat = SLAVE_DATA;
    forever begin
      @(negedge clk);
      cur_scl = scl;
      cur_sda = sda;
      if (resp_abort) begin
        in_frame   = 1'b0;
        rise_cnt   = 0;
        slv_oe     = 1'b0;
        resp_abort = 1'b0;
      end else if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
        chk("proto_start_in_frame", in_frame, 0);
        in_frame = 1'b1;
        rise_cnt = 0;
        fbits    = '0;
        slv_oe   = 1'b0;
      end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
        chk("proto_stop_in_frame", in_frame, 1);
        fr.bits  = fbits;
        fr.nbits = rise_cnt;
        frame_q.push_back(fr);
        in_frame = 1'b0;
        slv_oe   = 1'b0;
      end else if (in_frame && !prev_scl && cur_scl) begin
        fbits = {fbits[30:0], cur_sda};
        rise_cnt++;
        if (rise_cnt == 8) begin
          matched = (fbits[7:1] == SLAVE_ADDR);
          rd      = fbits[0];
        end
      end else if (in_frame && prev_scl && !cur_scl) begin
        if (rise_cnt == 8)                         slv_oe = matched;
        else if (rise_cnt >= 9 && rise_cnt <= 16)  slv_oe = matched && rd && !sdat[3'(16 - rise_cnt)];
        else if (rise_cnt == 17)                   slv_oe = matched && !rd;
        else                                       slv_oe = 1'b0;
      end
      prev_scl = cur_scl;
      prev_sda = cur_sda;
    end
  end

  initial begin : monitor
    exp_t   e;
    frame_t f;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done required=no_done");
        end else begin
          e = exp_q.pop_front();
          chk("latency", cyc - e.start, e.lat);
          chk("data_out", data_out, e.dout);
          chk("ack_err", ack_err, e.aerr);
          chk("busy_at_done", busy, 0);
          if (frame_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL missing_frame actual=none required=%0d_bits", e.nbits);
          end else begin
            f = frame_q.pop_front();
            chk("frame_len", f.nbits, e.nbits);
            chk("frame_bits", f.bits, e.bits);
          end
        end
      end
    end
  end

  // Reference: expected bus bits (one per SCL rise), result and frame length from the protocol rules
  task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d, input logic hold);
    exp_t       e;
    logic [7:0] b;
    e.bits  = '0;
    e.nbits = 0;
    b = {a, r};
    for (int i = 7; i >= 0; i--) begin
      e.bits = {e.bits[30:0], b[i]};
      e.nbits++;
    end
    if (a == SLAVE_ADDR) begin
      e.bits = {e.bits[30:0], 1'b0};
      e.nbits++;
      b = r ? SLAVE_DATA : d;
      for (int i = 7; i >= 0; i--) begin
        e.bits = {e.bits[30:0], b[i]};
        e.nbits++;
      end
      e.bits = {e.bits[30:0], r};
      e.bits = {e.bits[30:0], 1'b0};
      e.nbits += 2;
      e.aerr = 1'b0;
      e.lat  = 20 * PERIOD;
      if (r) model_dout = SLAVE_DATA;
    end else begin
      e.bits = {e.bits[29:0], 2'b10};
      e.nbits += 2;
      e.aerr = 1'b1;
      e.lat  = 11 * PERIOD;
    end
    e.dout  = model_dout;
    rw      = r;
    addr    = a;
    data_in = d;
    enable  = 1'b1;
    @(posedge clk);
    #1;
    e.start = cyc;
    exp_q.push_back(e);
    chk("busy_accept", busy, 1);
    if (!hold) enable = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < int'(25 * PERIOD); i++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout actual=no_done required=done");
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    exp_t       dropped;
    logic       r;
    logic [6:0] a;
    logic [7:0] d;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_data_out", data_out, model_dout);
    @(negedge clk);
    RST = 1'b0;
    repeat (2) @(negedge clk);

    issue(1'b0, SLAVE_ADDR, 8'hA5, 1'b0);
    wait_done();
    @(negedge clk);
    issue(1'b1, SLAVE_ADDR, 8'h00, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);
    issue(1'b0, 7'h11, 8'h3C, 1'b0);
    wait_done();
    issue(1'b1, 7'h11, 8'h00, 1'b0);
    wait_done();

    // A request while busy must not disturb the running frame or queue another
    issue(1'b0, SLAVE_ADDR, 8'h5A, 1'b0);
    repeat (30) @(negedge clk);
    rw     = 1'b1;
    addr   = 7'h11;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("idle_after_ignored", busy, 0);

    for (int n = 0; n < 12; n++) begin
      r = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 7'($urandom);
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(r, a, d, 1'b0);
      wait_done();
    end

    // Abort during address bit 3 (first quarter, SCL low), then a clean write
    @(negedge clk);
    issue(1'b0, SLAVE_ADDR, 8'hC3, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("pre_rst_scl_low", scl, 0);
    RST        = 1'b1;
    resp_abort = 1'b1;
    dropped    = exp_q.pop_back();
    model_dout = 8'h00;
    #1;
    chk("abort_scl", scl, 1);
    chk("abort_sda", sda, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ack_err", ack_err, 0);
    chk("abort_data_out", data_out, model_dout);
    repeat (2) @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    issue(1'b0, SLAVE_ADDR, 8'h96, 1'b0);
    wait_done();

    // enable held through done: back-to-back frames
    issue(1'b0, SLAVE_ADDR, 8'h0F, 1'b1);
    wait_done();
    issue(1'b1, SLAVE_ADDR, 8'h00, 1'b1);
    wait_done();
    issue(1'b0, 7'h11, 8'hFF, 1'b0);
    wait_done();

    repeat (6) @(negedge clk);
    chk("final_busy", busy, 0);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("frame_q_empty", frame_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
